// File: rtl/rgb_led_driver.sv
// RGB status LED driver: steady, blink and single-pulse lighting
// with per-channel PWM dimming behind a valid/ready command port.
module rgb_led_driver #(
  parameter int PWM_BITS    = 4,
  parameter int DIV         = 50000,
  parameter int BLINK_TICKS = 250,
  parameter int PULSE_TICKS = 500
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [2:0]          color_in,
  input  logic [1:0]          mode_in,
  input  logic [PWM_BITS-1:0] bright_in,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  output logic                led_r,
  output logic                led_g,
  output logic                led_b,
  output logic                busy
);

  localparam int PW   = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int TMAX = (BLINK_TICKS > PULSE_TICKS) ?
                        BLINK_TICKS : PULSE_TICKS;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [PW-1:0] PS_LAST = PW'(DIV - 1);
  localparam logic [TW-1:0] BT      = TW'(BLINK_TICKS);
  localparam logic [TW-1:0] PT      = TW'(PULSE_TICKS);
  localparam logic [PWM_BITS-1:0] BR_FULL = '1;

  typedef enum logic [2:0] {
    S_OFF,
    S_STEADY,
    S_BLINK_ON,
    S_BLINK_OFF,
    S_PULSE
  } state_e;

  state_e              state_q, state_d;
  logic [2:0]          color_q, color_d;
  logic [PWM_BITS-1:0] bright_q, bright_d;
  logic [PWM_BITS-1:0] pwm_q;
  logic [PW-1:0]       ps_q, ps_d;
  logic [TW-1:0]       tcnt_q, tcnt_d;
  logic [2:0]          led_q, led_d;
  logic [TW-1:0]       lim;

  logic accept;
  logic tick;
  logic lit;
  logic pwm_on;

  assign cmd_ready = (state_q != S_PULSE);
  assign busy      = (state_q == S_PULSE);
  assign accept    = cmd_valid && cmd_ready;
  assign tick      = (ps_q == PS_LAST);
  assign lit       = state_q inside {S_STEADY, S_BLINK_ON, S_PULSE};
  assign pwm_on    = (bright_q == BR_FULL) || (pwm_q < bright_q);
  assign lim       = (state_q == S_PULSE) ? PT : BT;

  assign led_r = led_q[2];
  assign led_g = led_q[1];
  assign led_b = led_q[0];

  always_comb begin
    state_d  = state_q;
    color_d  = color_q;
    bright_d = bright_q;
    tcnt_d   = tcnt_q;
    ps_d     = tick ? '0 : ps_q + 1'b1;
    led_d    = color_q & {3{lit && pwm_on}};
    if (accept) begin
      color_d  = color_in;
      bright_d = bright_in;
      ps_d     = '0;
      tcnt_d   = '0;
      unique case (mode_in)
        2'b00: state_d = S_OFF;
        2'b01: state_d = S_STEADY;
        2'b10: state_d = S_BLINK_ON;
        2'b11: state_d = S_PULSE;
      endcase
    end else if (tick) begin
      // Only the timed states consume ticks.
      unique case (state_q)
        S_BLINK_ON, S_BLINK_OFF, S_PULSE: begin
          if (tcnt_q + TW'(1) == lim) begin
            tcnt_d = '0;
            unique case (state_q)
              S_BLINK_ON:  state_d = S_BLINK_OFF;
              S_BLINK_OFF: state_d = S_BLINK_ON;
              default:     state_d = S_OFF;
            endcase
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_OFF;
      color_q  <= '0;
      bright_q <= '0;
      pwm_q    <= '0;
      ps_q     <= '0;
      tcnt_q   <= '0;
      led_q    <= '0;
    end else begin
      state_q  <= state_d;
      color_q  <= color_d;
      bright_q <= bright_d;
      pwm_q    <= pwm_q + 1'b1;
      ps_q     <= ps_d;
      tcnt_q   <= tcnt_d;
      led_q    <= led_d;
    end
  end

endmodule

// File: tb/tb_rgb_led_driver.sv
// Bench for rgb_led_driver: directed plan steps plus random commands
// checked against a phase-arithmetic model of the lighting rules.
module tb_rgb_led_driver;

  localparam int PB = 4;
  localparam int DV = 4;
  localparam int BT = 3;
  localparam int PT = 5;

  logic          clock = 1'b0;
  logic          reset_n;
  logic [2:0]    color_in;
  logic [1:0]    mode_in;
  logic [PB-1:0] bright_in;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          led_r, led_g, led_b;
  logic          busy;
  logic [2:0]    led;

  int checks = 0;
  int errors = 0;

  int         edges  = 0;
  int         c_edge = 0;
  logic [1:0] c_mode = 2'b00;
  logic [2:0] c_color = 3'b000;
  logic [3:0] c_bright = 4'h0;

  assign led = {led_r, led_g, led_b};

  always #5 clock = ~clock;

  rgb_led_driver #(
    .PWM_BITS(PB),
    .DIV(DV),
    .BLINK_TICKS(BT),
    .PULSE_TICKS(PT)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .color_in(color_in),
    .mode_in(mode_in),
    .bright_in(bright_in),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .led_r(led_r),
    .led_g(led_g),
    .led_b(led_b),
    .busy(busy)
  );

  // Ready after edge k: only a pulse still inside its lit window blocks.
  function automatic bit m_ready(int k);
    return !(c_mode == 2'b11 && (k - c_edge) < DV * PT);
  endfunction

  // Pins after edge k follow the command state and pwm count of edge k-1.
  function automatic logic [2:0] m_led(int k);
    int m;
    int p;
    bit lt;
    bit on;
    m = k - 1 - c_edge;
    p = (k - 1) % (1 << PB);
    case (c_mode)
      2'b00:   lt = 1'b0;
      2'b01:   lt = 1'b1;
      2'b10:   lt = ((m / (DV * BT)) % 2) == 0;
      default: lt = m < DV * PT;
    endcase
    on = (c_bright == 4'hF) || (p < int'(c_bright));
    return (lt && on) ? c_color : 3'b000;
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h (edge %0d)",
             tag, got, exp, edges);
    end
  endtask

  task automatic step();
    logic [2:0] e_led;
    @(posedge clock);
    edges++;
    e_led = m_led(edges);
    if (cmd_valid && m_ready(edges - 1)) begin
      c_edge   = edges;
      c_mode   = mode_in;
      c_color  = color_in;
      c_bright = bright_in;
    end
    #1;
    chk("led", led, e_led);
    chk("cmd_ready", cmd_ready, m_ready(edges));
    chk("busy", busy, !m_ready(edges));
  endtask

  task automatic cmd(logic [1:0] m, logic [2:0] c, logic [3:0] b);
    mode_in   = m;
    color_in  = c;
    bright_in = b;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic model_reset();
    edges    = 0;
    c_edge   = 0;
    c_mode   = 2'b00;
    c_color  = 3'b000;
    c_bright = 4'h0;
  endtask

  initial begin
    int cnt;
    reset_n   = 1'b0;
    color_in  = 3'b000;
    mode_in   = 2'b00;
    bright_in = '0;
    cmd_valid = 1'b0;
    #12;
    chk("rst_led", led, 3'b000);
    chk("rst_ready", cmd_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    #11;
    reset_n = 1'b1;
    model_reset();
    repeat (3) step();

    // STEADY, magenta, full brightness
    cmd(2'b01, 3'b101, 4'hF);
    repeat (20) begin
      step();
      chk("steady_full", led, 3'b101);
    end

    // STEADY, green, quarter duty
    cmd(2'b01, 3'b010, 4'h4);
    cnt = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (i >= 17 && i <= 32 && led_g) cnt++;
      chk("dim_rb", {led_r, led_b}, 2'b00);
    end
    chk("dim_g_window", cnt, 4);

    // BLINK white
    cmd(2'b10, 3'b111, 4'hF);
    repeat (50) step();

    // PULSE red, with an ignored STEADY mid-pulse
    cmd(2'b11, 3'b100, 4'hF);
    cnt = 0;
    for (int i = 1; i <= 30; i++) begin
      if (i == 8) begin
        mode_in   = 2'b01;
        color_in  = 3'b010;
        bright_in = 4'hF;
        cmd_valid = 1'b1;
      end
      if (i == 11) cmd_valid = 1'b0;
      step();
      if (led_r) cnt++;
      if (i <= 19) chk("pulse_busy", busy, 1'b1);
    end
    chk("pulse_len", cnt, 20);
    chk("pulse_end_ready", cmd_ready, 1'b1);

    // Asynchronous reset mid-blink
    cmd(2'b10, 3'b111, 4'hF);
    repeat (5) step();
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_led", led, 3'b000);
    chk("async_ready", cmd_ready, 1'b1);
    chk("async_busy", busy, 1'b0);
    #10;
    reset_n = 1'b1;
    model_reset();
    repeat (30) begin
      step();
      chk("post_rst_off", led, 3'b000);
    end

    // BLINK then OFF; then STEADY at zero brightness
    cmd(2'b10, 3'b111, 4'hF);
    repeat (4) step();
    cmd(2'b00, 3'b111, 4'hF);
    repeat (10) begin
      step();
      chk("off_cmd", led, 3'b000);
    end
    cmd(2'b01, 3'b111, 4'h0);
    repeat (20) begin
      step();
      chk("bright0", led, 3'b000);
    end

    // Random command stream
    for (int i = 0; i < 900; i++) begin
      cmd_valid = ($urandom_range(0, 19) == 0);
      mode_in   = 2'($urandom_range(0, 3));
      color_in  = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0:       bright_in = 4'h0;
        1:       bright_in = 4'hF;
        default: bright_in = 4'($urandom_range(0, 15));
      endcase
      step();
    end
    cmd_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/rgb_led_driver.md
Name: rgb_led_driver

Overview:
Drives the three physical pins of the alarm's RGB status LED. It accepts a 3-bit color code (bit2 = R, bit1 = G, bit0 = B, the same encoding the rgb color source produces) together with a display mode and a brightness through a valid/ready handshake. It then generates steady, blinking or single-pulse lighting with per-channel PWM dimming. It sits between the alarm control logic or color source and the board LED pins.

Parameters:
PWM_BITS, 4, width of the brightness value and of the PWM counter
DIV, 50000, clock cycles per timebase tick (minimum 2)
BLINK_TICKS, 250, ticks per blink half-period (ON or OFF phase)
PULSE_TICKS, 500, ticks the LED stays lit in PULSE mode

Ports:
clock  in  1  system clock; all state updates on rising edge
reset_n  in  1  asynchronous, active-low reset
color_in  in  3  requested color {R,G,B}
mode_in  in  2  00 OFF, 01 STEADY, 10 BLINK, 11 PULSE
bright_in  in  PWM_BITS  requested brightness; 0 = dark, all-ones = fully on
cmd_valid  in  1  command present
cmd_ready  out  1  driver accepts a command this cycle
led_r  out  1  red pin, active-high
led_g  out  1  green pin, active-high
led_b  out  1  blue pin, active-high
busy  out  1  high while in the PULSE state

Behaviour:
- Reset (reset_n low, asynchronous): state OFF; color_reg, bright_reg, pwm_cnt, prescaler and tick counter are 0; led_r/g/b = 0; cmd_ready = 1; busy = 0.
- Handshake: a command is accepted on a rising edge where cmd_valid && cmd_ready. color_in, mode_in and bright_in are latched into registers. cmd_valid while cmd_ready = 0 is ignored and not queued.
- cmd_ready = 1 in every state except PULSE.
- States are OFF, STEADY, BLINK_ON, BLINK_OFF and PULSE. An accepted command moves the state according to mode: 00 to OFF, 01 to STEADY, 10 to BLINK_ON, 11 to PULSE.
- Every accepted command clears the prescaler and the tick counter, so the blink and pulse timing restarts from phase 0.
- Timebase: the prescaler counts 0 to DIV-1 and wraps. A tick is one cycle, asserted when prescaler = DIV-1. The tick counter counts ticks only in BLINK_ON, BLINK_OFF and PULSE.
- BLINK_ON goes to BLINK_OFF on the tick that brings the tick count to BLINK_TICKS; the tick counter then clears. BLINK_OFF returns to BLINK_ON the same way.
- PULSE goes to OFF on the tick reaching PULSE_TICKS. cmd_ready rises in the cycle after that transition.
- The state is lit in STEADY, BLINK_ON and PULSE; it is unlit in OFF and BLINK_OFF.
- PWM: pwm_cnt is a free-running PWM_BITS counter that increments every clock and wraps from all-ones to 0. pwm_on = (bright_reg == all-ones) || (pwm_cnt < bright_reg). bright_reg = 0 gives a permanently dark output.
- Output: led_x <= color_reg[x] && lit && pwm_on. The outputs are registered, so there are no glitches on the pins.
- Latency: for a command accepted at edge N, the registers update at N and led_* reflects the new command from edge N+1.
- Back-to-back commands: each accepted command fully replaces the previous one; there is no merging.
- Reset asserted mid-PULSE or mid-blink: the block returns immediately to the reset values above.
- busy = 1 exactly while the state is PULSE.

Test Plan (sim parameters: PWM_BITS=4, DIV=4, BLINK_TICKS=3, PULSE_TICKS=5):
- Reset, then a STEADY command with color 101 and bright 1111 accepted at edge N -> led_r=1, led_g=0, led_b=1 from edge N+1 and held constant; cmd_ready stays 1.
- STEADY, color 010, bright 0100 -> over every 16-cycle window led_g is high exactly 4 cycles (pwm_cnt 0..3); led_r = led_b = 0 throughout.
- BLINK, color 111, bright 1111 -> all pins high for 12 cycles, then low for 12 cycles, repeating; the phase starts lit at N+1.
- PULSE, color 100, bright 1111 -> led_r high for 20 cycles; busy = 1 and cmd_ready = 0 during the pulse; a STEADY command presented mid-pulse is ignored; the block then goes to OFF with cmd_ready = 1.
- Assert reset_n low mid-BLINK, asynchronously between edges -> led_* = 0 and cmd_ready = 1 without waiting for a clock; after release the state is OFF.
- BLINK command followed by an OFF command 5 cycles later -> all pins 0 from the edge after acceptance; bright 0000 with STEADY also keeps all pins 0.
